taus_multi: RTL and testbench
=============================

Name: taus_multi

Overview:
- Multi-channel Tausworthe (taus88) uniform random number generator; successor to the single-channel 32-bit generator.
- NUM_CH independent three-component generators, seeded per component over a write port.
- Programmable warm-up run discards the first outputs after seeding.
- Outputs over a valid/ready stream, so downstream Box-Muller / AWGN stages can stall without losing or repeating samples.

Parameters:
- NUM_CH, 4, number of independent generator channels (1..16).
- WARMUP, 16, free-running steps after start before out_valid asserts (0 allowed).
- CH_W, $clog2(NUM_CH) min 1, width of seed_ch (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- seed_wr  in  1  one-cycle seed write strobe.
- seed_ch  in  CH_W  channel addressed by seed_wr.
- seed_sel  in  2  component select: 0=s0, 1=s1, 2=s2, 3=ignored (write dropped).
- seed_data  in  32  seed value.
- start  in  1  pulse: begin warm-up, then stream.
- busy  out  1  high during warm-up.
- out_valid  out  1  out_data holds a fresh sample set.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_CH*32  channel c at bits [32c+31:32c].

Behaviour:
- Reset (reset_n low, async assert, sync-released by the caller):
  - all s0/s1/s2 = 0;
  - FSM = UNSEEDED;
  - warm-up counter = 0;
  - out_valid = 0, busy = 0, out_data = 0.
- Step function per channel, unsigned 32-bit arithmetic with shifts that discard overflow:
  - s0' = ((s0 & 0xFFFFFFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19)
  - s1' = ((s1 & 0xFFFFFFF8) << 4) ^ (((s1 << 2) ^ s1) >> 25)
  - s2' = ((s2 & 0xFFFFFFF0) << 17) ^ (((s2 << 3) ^ s2) >> 11)
- out_data[c] = s0[c] ^ s1[c] ^ s2[c], combinational from state registers only (no input-to-output path).
- All channels step together and never independently.
- FSM UNSEEDED:
  - out_valid = 0; state holds.
  - start -> WARMUP with counter = WARMUP, or -> RUN if WARMUP = 0.
- FSM WARMUP:
  - busy = 1; all channels step every cycle; counter decrements.
  - Counter reaching 1 with a step taken -> RUN next cycle.
  - Exactly WARMUP steps occur.
- FSM RUN:
  - out_valid = 1.
  - Step only on fire (out_valid & out_ready).
  - With out_ready low, out_data is stable indefinitely.
  - start in RUN re-enters WARMUP from the current state; out_valid drops the next cycle.
- Seed write, any state: seed_wr writes seed_data to the selected component of seed_ch at the clock edge.
  - FSM -> UNSEEDED next cycle; out_valid falls; any in-flight warm-up is aborted.
  - An out_ready in that same cycle is not a fire for stepping purposes: the write wins, no step.
- seed_wr and start in the same cycle: write applied, start ignored, FSM = UNSEEDED.
- seed_ch >= NUM_CH or seed_sel = 3: no register changes, but FSM still -> UNSEEDED.
- Latency:
  - start to first out_valid = WARMUP+1 cycles.
  - Fire to next sample = next cycle (one sample per cycle sustained throughput).

Optional Feature:
- Macro TAUS_SEED_FIX_EN.
- Defined: seed writes are sanitised before storing, so degenerate seeds can never lock a component at zero.
  - s0 stored as seed_data | 0x2 when seed_data < 2.
  - s1 stored as seed_data | 0x8 when seed_data < 8.
  - s2 stored as seed_data | 0x10 when seed_data < 16.
- Not defined: seed_data stored raw; all-zero seeds yield constant 0 output (legal, documented).

Decomposition:
- taus_pkg holds:
  - TAUS_W = 32;
  - mask constants 0xFFFFFFFE/0xFFFFFFF8/0xFFFFFFF0;
  - shift constants (12,13,19 / 4,2,25 / 17,3,11);
  - minimum-seed constants 2/8/16;
  - FSM enum {UNSEEDED, WARMUP, RUN}.
- Sub-module taus_lane:
  - one channel's three state registers, step logic, seed write decode and optional sanitiser.
  - Inputs: step, wr_en, sel, data. Output: 32-bit sample.
- taus_multi instantiates NUM_CH lanes and owns the FSM and warm-up counter.

Test Plan:
- Reset, seed ch0 s0/s1/s2 = 12345/12345/12345, start, out_ready=1 -> after WARMUP cycles, 1000 samples match the C taus88 golden model advanced 16 steps; ch0 differs from unseeded channels.
- All seeds 0, feature off, start -> out_valid after 17 cycles, out_data = 0 for 100 fires; feature on -> first sample equals the golden model from seeds 2/8/16.
- RUN with out_ready toggling randomly 50% -> accepted sequence identical to the out_ready=1 sequence; no repeats or skips; out_data stable while stalled.
- seed_wr mid-WARMUP (cycle 5) -> busy drops, FSM UNSEEDED; next start yields a full 16-step warm-up from the new seeds.
- seed_wr and start in the same cycle -> out_valid stays 0; seed_sel=3 write -> state unchanged, out_valid still drops.
- reset_n asserted mid-RUN asynchronously -> out_valid and out_data = 0 before the next clock edge; WARMUP=0 build -> out_valid one cycle after start.

Source files
------------

// File: rtl/taus_pkg.sv
// Shared constants, step helpers and FSM states for the taus88 generator.
// Masks, shift amounts and minimum seeds for the three components.
package taus_pkg;

  localparam int TAUS_W = 32;

  localparam logic [TAUS_W-1:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [TAUS_W-1:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [TAUS_W-1:0] MASK2 = 32'hFFFF_FFF0;

  localparam int SH0A = 12;
  localparam int SH0B = 13;
  localparam int SH0C = 19;
  localparam int SH1A = 4;
  localparam int SH1B = 2;
  localparam int SH1C = 25;
  localparam int SH2A = 17;
  localparam int SH2B = 3;
  localparam int SH2C = 11;

  localparam logic [TAUS_W-1:0] MIN0 = 32'd2;
  localparam logic [TAUS_W-1:0] MIN1 = 32'd8;
  localparam logic [TAUS_W-1:0] MIN2 = 32'd16;

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARMUP,
    ST_RUN
  } taus_state_e;

  function automatic logic [TAUS_W-1:0] step0(
    input logic [TAUS_W-1:0] s
  );
    return ((s & MASK0) << SH0A) ^ (((s << SH0B) ^ s) >> SH0C);
  endfunction

  function automatic logic [TAUS_W-1:0] step1(
    input logic [TAUS_W-1:0] s
  );
    return ((s & MASK1) << SH1A) ^ (((s << SH1B) ^ s) >> SH1C);
  endfunction

  function automatic logic [TAUS_W-1:0] step2(
    input logic [TAUS_W-1:0] s
  );
    return ((s & MASK2) << SH2A) ^ (((s << SH2B) ^ s) >> SH2C);
  endfunction

endpackage

// File: rtl/taus_lane.sv
// One taus88 channel: three component registers, step and seed write.
// Ports: clk, reset_n, step, wr_en, sel, data in; sample out.
// Macro TAUS_SEED_FIX_EN: sanitise degenerate seeds on write.
module taus_lane
  import taus_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              wr_en,
  input  logic [1:0]        sel,
  input  logic [TAUS_W-1:0] data,
  output logic [TAUS_W-1:0] sample
);

  logic [TAUS_W-1:0] s0;
  logic [TAUS_W-1:0] s1;
  logic [TAUS_W-1:0] s2;
  logic [TAUS_W-1:0] w0;
  logic [TAUS_W-1:0] w1;
  logic [TAUS_W-1:0] w2;

  always_comb begin
    w0 = data;
    w1 = data;
    w2 = data;
`ifdef TAUS_SEED_FIX_EN
    // Seeds below the minimum would leave a component stuck at zero.
    if (data < MIN0) w0 = data | MIN0;
    if (data < MIN1) w1 = data | MIN1;
    if (data < MIN2) w2 = data | MIN2;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        (sel == 2'd0): s0 <= w0;
        (sel == 2'd1): s1 <= w1;
        (sel == 2'd2): s2 <= w2;
        default: ;
      endcase
    end else if (step) begin
      s0 <= step0(s0);
      s1 <= step1(s1);
      s2 <= step2(s2);
    end
  end

  assign sample = s0 ^ s1 ^ s2;

endmodule

// File: rtl/taus_multi.sv
// Multi-channel taus88 generator with warm-up and valid/ready output.
// Ports: seed write port, start, busy, out_valid/out_ready/out_data.
// Macro TAUS_SEED_FIX_EN (passed to lanes): seed sanitiser.
module taus_multi
  import taus_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WARMUP = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     seed_wr,
  input  logic [CH_W-1:0]          seed_ch,
  input  logic [1:0]               seed_sel,
  input  logic [TAUS_W-1:0]        seed_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*TAUS_W-1:0] out_data
);

  localparam int CNT_W =
    (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP);

  taus_state_e      state_q;
  taus_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_UNSEEDED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    unique case (state_q)
      ST_UNSEEDED: begin
        if (start) begin
          state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WARMUP: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        step = out_ready;
        if (start) begin
          state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          cnt_d   = CNT_INIT;
        end
      end
      default: state_d = ST_UNSEEDED;
    endcase
    // A seed write overrides everything, including a same-cycle fire.
    if (seed_wr) begin
      state_d = ST_UNSEEDED;
      cnt_d   = '0;
      step    = 1'b0;
    end
  end

  assign busy      = (state_q == ST_WARMUP);
  assign out_valid = (state_q == ST_RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic wr_en;
    assign wr_en = seed_wr && (seed_ch == CH_W'(c));
    taus_lane u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .step   (step),
      .wr_en  (wr_en),
      .sel    (seed_sel),
      .data   (seed_data),
      .sample (out_data[TAUS_W*c +: TAUS_W])
    );
  end

endmodule

// File: tb/tb_taus_multi.sv
// Directed self-checking bench for taus_multi against a taus88 model.
// Second instance exercises the zero warm-up configuration.
module tb_taus_multi;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         seed_wr = 1'b0;
  logic [1:0]   seed_ch = '0;
  logic [1:0]   seed_sel = '0;
  logic [31:0]  seed_data = '0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         out_valid;
  logic [127:0] out_data;
  logic         z_busy;
  logic         z_valid;
  logic [63:0]  z_data;

  int total = 0;
  int bad = 0;

  logic [31:0] m0 [4];
  logic [31:0] m1 [4];
  logic [31:0] m2 [4];

  always #5 clk = ~clk;

  taus_multi #(.NUM_CH(4), .WARMUP(16)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .seed_wr  (seed_wr),
    .seed_ch  (seed_ch),
    .seed_sel (seed_sel),
    .seed_data(seed_data),
    .start    (start),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  taus_multi #(.NUM_CH(2), .WARMUP(0)) u_z (
    .clk      (clk),
    .reset_n  (reset_n),
    .seed_wr  (seed_wr),
    .seed_ch  (seed_ch[0:0]),
    .seed_sel (seed_sel),
    .seed_data(seed_data),
    .start    (start),
    .busy     (z_busy),
    .out_valid(z_valid),
    .out_ready(out_ready),
    .out_data (z_data)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] g0(input logic [31:0] s);
    return ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] g1(input logic [31:0] s);
    return ((s & 32'hFFFFFFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] g2(input logic [31:0] s);
    return ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  task automatic mstep(input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < 4; c++) begin
        m0[c] = g0(m0[c]);
        m1[c] = g1(m1[c]);
        m2[c] = g2(m2[c]);
      end
  endtask

  task automatic mreset();
    for (int c = 0; c < 4; c++) begin
      m0[c] = '0;
      m1[c] = '0;
      m2[c] = '0;
    end
  endtask

  function automatic logic [127:0] expd();
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      r[32*c +: 32] = m0[c] ^ m1[c] ^ m2[c];
    return r;
  endfunction

  // Model side of a seed write; sel 3 stores nothing.
  task automatic mwrite(input int ch, input int sel,
                        input logic [31:0] d);
    logic [31:0] v0, v1, v2;
    v0 = d;
    v1 = d;
    v2 = d;
`ifdef TAUS_SEED_FIX_EN
    if (d < 2)  v0 = d | 32'h2;
    if (d < 8)  v1 = d | 32'h8;
    if (d < 16) v2 = d | 32'h10;
`endif
    if (sel == 0) m0[ch] = v0;
    if (sel == 1) m1[ch] = v1;
    if (sel == 2) m2[ch] = v2;
  endtask

  task automatic wr_seed(input int ch, input int sel,
                         input logic [31:0] d);
    seed_wr   = 1'b1;
    seed_ch   = 2'(ch);
    seed_sel  = 2'(sel);
    seed_data = d;
    tick();
    seed_wr = 1'b0;
    mwrite(ch, sel, d);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called one cycle after the start edge; expects 16 more edges.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    chk({tag, "_busy"}, 128'(busy), 128'd1);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd16);
    mstep(16);
  endtask

  initial begin
    mreset();
    tick();
    tick();
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_data", out_data, 128'd0);
    reset_n = 1'b1;
    tick();

    // Seed channel 0 and run the warm-up.
    wr_seed(0, 0, 32'd12345);
    wr_seed(0, 1, 32'd12345);
    wr_seed(0, 2, 32'd12345);
    chk("unseeded_valid", 128'(out_valid), 128'd0);
    do_start();
    chk("z_valid", 128'(z_valid), 128'd1);
    chk("z_busy", 128'(z_busy), 128'd0);
    chk("wu_valid", 128'(out_valid), 128'd0);
    wait_valid("wu1");
    chk("ch0_ne_ch1",
        128'(out_data[31:0] != out_data[63:32]), 128'd1);

    // Sustained stream.
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      chk("stream", out_data, expd());
      tick();
      mstep(1);
    end

    // Random stalls: no skip, no repeat, stable while held.
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_data", out_data, expd());
      tick();
      if (out_ready) mstep(1);
    end
    out_ready = 1'b0;
    tick();
    chk("hold_data", out_data, expd());

    // Seed write aborts a warm-up in progress.
    do_start();
    chk("rerun_valid", 128'(out_valid), 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      mstep(1);
    end
    wr_seed(1, 0, 32'd777);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_valid", 128'(out_valid), 128'd0);
    tick();
    tick();
    chk("abort_hold", out_data, expd());
    do_start();
    wait_valid("wu2");
    chk("wu2_data", out_data, expd());

    // Seed write and start together: start is dropped.
    seed_wr   = 1'b1;
    start     = 1'b1;
    seed_ch   = 2'd2;
    seed_sel  = 2'd1;
    seed_data = 32'd4242;
    tick();
    seed_wr = 1'b0;
    start   = 1'b0;
    mwrite(2, 1, 32'd4242);
    chk("ws_valid", 128'(out_valid), 128'd0);
    chk("ws_busy", 128'(busy), 128'd0);
    tick();
    chk("ws_valid2", 128'(out_valid), 128'd0);
    chk("ws_data", out_data, expd());
    do_start();
    wait_valid("wu3");
    chk("wu3_data", out_data, expd());

    // sel 3 writes nothing but still leaves RUN.
    wr_seed(1, 3, 32'hDEADBEEF);
    chk("sel3_valid", 128'(out_valid), 128'd0);
    chk("sel3_data", out_data, expd());
    do_start();
    wait_valid("wu4");

    // Write beats a same-cycle fire.
    out_ready = 1'b1;
    wr_seed(3, 2, 32'd99);
    chk("wfire_valid", 128'(out_valid), 128'd0);
    chk("wfire_data", out_data, expd());
    out_ready = 1'b0;
    do_start();
    wait_valid("wu5");
    chk("wu5_data", out_data, expd());

    // Asynchronous reset clears outputs before the next edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_data", out_data, 128'd0);
    tick();
    reset_n = 1'b1;
    mreset();
    tick();

    // Zero seeds: constant zero raw, or sanitised minimum seeds.
    wr_seed(0, 0, 32'd0);
    wr_seed(0, 1, 32'd0);
    wr_seed(0, 2, 32'd0);
    do_start();
    wait_valid("wu6");
`ifndef TAUS_SEED_FIX_EN
    chk("zero_out", out_data, 128'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("zero_stream", out_data, expd());
      tick();
      mstep(1);
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
